// File: rtl/ascon_pkg.sv
// ascon_pkg: shared Ascon state types
package ascon_pkg;

    localparam int WORD_WIDTH = 64;

    // Five 64-bit words; s[0] supplies the MSB of every 5-bit column.
    typedef logic [4:0][WORD_WIDTH-1:0] ascon_state_t;

endpackage

// File: rtl/ascon_inv_sbox_serial.sv
// ascon_inv_sbox_serial: serialized inverse Ascon S-box layer, LANES columns per cycle
module ascon_inv_sbox_serial #(
    parameter int LANES = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  ascon_pkg::ascon_state_t state_array_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output ascon_pkg::ascon_state_t state_array_o
);

    localparam int GROUPS = 64 / LANES;
    localparam int CW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(GROUPS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 &&
        LANES != 16 && LANES != 32 && LANES != 64) begin : g_lanes_chk
        $error("ascon_inv_sbox_serial: LANES must be a power of two from 1 to 64");
    end

    logic [1:0]              st_q, st_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    ascon_pkg::ascon_state_t col_q, col_d, sub_col;
    logic [5:0]              idx;
    logic [4:0]              y;

    function automatic logic [4:0] inv5(input logic [4:0] x);
        case (x)
            5'h00: return 5'h14;
            5'h01: return 5'h1a;
            5'h02: return 5'h07;
            5'h03: return 5'h0d;
            5'h04: return 5'h00;
            5'h05: return 5'h09;
            5'h06: return 5'h0e;
            5'h07: return 5'h12;
            5'h08: return 5'h0a;
            5'h09: return 5'h06;
            5'h0a: return 5'h1d;
            5'h0b: return 5'h01;
            5'h0c: return 5'h19;
            5'h0d: return 5'h15;
            5'h0e: return 5'h13;
            5'h0f: return 5'h1e;
            5'h10: return 5'h18;
            5'h11: return 5'h16;
            5'h12: return 5'h0b;
            5'h13: return 5'h11;
            5'h14: return 5'h03;
            5'h15: return 5'h05;
            5'h16: return 5'h1c;
            5'h17: return 5'h1f;
            5'h18: return 5'h17;
            5'h19: return 5'h1b;
            5'h1a: return 5'h04;
            5'h1b: return 5'h08;
            5'h1c: return 5'h0f;
            5'h1d: return 5'h0c;
            5'h1e: return 5'h10;
            default: return 5'h02;
        endcase
    endfunction

    // Substitute only the current group of LANES columns; the rest pass through untouched.
    always_comb begin
        sub_col = col_q;
        idx = '0;
        y = '0;
        for (int l = 0; l < LANES; l++) begin
            idx = 6'(int'(cnt_q) * LANES + l);
            y = inv5({col_q[0][idx], col_q[1][idx], col_q[2][idx], col_q[3][idx], col_q[4][idx]});
            sub_col[0][idx] = y[4];
            sub_col[1][idx] = y[3];
            sub_col[2][idx] = y[2];
            sub_col[3][idx] = y[1];
            sub_col[4][idx] = y[0];
        end
    end

    // Accept in IDLE, sweep column groups in BUSY, hold the result in DONE until taken.
    always_comb begin
        st_d = st_q;
        cnt_d = cnt_q;
        col_d = col_q;
        case (st_q)
            IDLE: if (valid_i) begin
                col_d = state_array_i;
                cnt_d = '0;
                st_d = BUSY;
            end
            BUSY: begin
                col_d = sub_col;
                cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
                st_d = (cnt_q == LAST) ? DONE : BUSY;
            end
            DONE: st_d = ready_i ? IDLE : DONE;
            default: st_d = IDLE;
        endcase
    end

    // State registers with synchronous reset that clears any partial result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q <= IDLE;
            cnt_q <= '0;
            col_q <= '0;
        end else begin
            st_q <= st_d;
            cnt_q <= cnt_d;
            col_q <= col_d;
        end
    end

    assign ready_o = (st_q == IDLE);
    assign valid_o = (st_q == DONE);
    assign state_array_o = col_q;

endmodule

// File: tb/tb_ascon_inv_sbox_serial.sv
// tb_ascon_inv_sbox_serial: directed checks of the serialized inverse S-box layer
module tb_ascon_inv_sbox_serial;
    import ascon_pkg::*;

    localparam logic [4:0] INV_T [32] = '{
        5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
        5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
        5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
        5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02};
    localparam logic [4:0] FWD_T [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    logic clk, rst;
    logic vi [4];
    logic ri [4];
    logic vo [4];
    logic ro [4];
    ascon_state_t si [4];
    ascon_state_t so [4];
    int total, bad;

    ascon_inv_sbox_serial #(.LANES(1)) u_l1 (
        .clk_i(clk), .rst_i(rst), .valid_i(vi[0]), .ready_o(ro[0]), .state_array_i(si[0]),
        .valid_o(vo[0]), .ready_i(ri[0]), .state_array_o(so[0]));
    ascon_inv_sbox_serial #(.LANES(4)) u_l4 (
        .clk_i(clk), .rst_i(rst), .valid_i(vi[1]), .ready_o(ro[1]), .state_array_i(si[1]),
        .valid_o(vo[1]), .ready_i(ri[1]), .state_array_o(so[1]));
    ascon_inv_sbox_serial #(.LANES(8)) u_l8 (
        .clk_i(clk), .rst_i(rst), .valid_i(vi[2]), .ready_o(ro[2]), .state_array_i(si[2]),
        .valid_o(vo[2]), .ready_i(ri[2]), .state_array_o(so[2]));
    ascon_inv_sbox_serial #(.LANES(64)) u_l64 (
        .clk_i(clk), .rst_i(rst), .valid_i(vi[3]), .ready_o(ro[3]), .state_array_i(si[3]),
        .valid_o(vo[3]), .ready_i(ri[3]), .state_array_o(so[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ascon_state_t apply_tab(input ascon_state_t s, input logic fwd);
        ascon_state_t r;
        logic [4:0] c, v;
        r = '0;
        for (int j = 0; j < 64; j++) begin
            c = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
            v = fwd ? FWD_T[c] : INV_T[c];
            r[0][j] = v[4];
            r[1][j] = v[3];
            r[2][j] = v[2];
            r[3][j] = v[1];
            r[4][j] = v[0];
        end
        return r;
    endfunction

    function automatic ascon_state_t rand_state();
        ascon_state_t s;
        for (int r = 0; r < 5; r++) s[r] = {$urandom(), $urandom()};
        return s;
    endfunction

    task automatic run_job(input int k, input ascon_state_t st, output int lat, output ascon_state_t res);
        @(negedge clk);
        vi[k] = 1'b1;
        si[k] = st;
        @(negedge clk);
        vi[k] = 1'b0;
        lat = 0;
        while (vo[k] !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        res = so[k];
    endtask

    task automatic release_job(input int k);
        ri[k] = 1'b1;
        @(negedge clk);
        ri[k] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vi[k] = 1'b0;
            ri[k] = 1'b0;
            si[k] = '0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (ro[k] !== 1'b1) begin bad++; $display("FAIL reset_ready inst=%0d got=%b exp=1", k, ro[k]); end
            total++;
            if (vo[k] !== 1'b0) begin bad++; $display("FAIL reset_valid inst=%0d got=%b exp=0", k, vo[k]); end
            total++;
            if (so[k] !== '0) begin bad++; $display("FAIL reset_state inst=%0d got=%h exp=0", k, so[k]); end
        end
        rst = 1'b0;
    endtask

    task automatic test_zero;
        int lat;
        ascon_state_t res;
        run_job(2, '0, lat, res);
        total++;
        if (lat != 8) begin bad++; $display("FAIL zero_latency got=%0d exp=8", lat); end
        total++;
        if (res[0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL zero_s0 got=%h exp=ffffffffffffffff", res[0]); end
        total++;
        if (res[1] !== 64'h0) begin bad++; $display("FAIL zero_s1 got=%h exp=0", res[1]); end
        total++;
        if (res[2] !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL zero_s2 got=%h exp=ffffffffffffffff", res[2]); end
        total++;
        if (res[3] !== 64'h0) begin bad++; $display("FAIL zero_s3 got=%h exp=0", res[3]); end
        total++;
        if (res[4] !== 64'h0) begin bad++; $display("FAIL zero_s4 got=%h exp=0", res[4]); end
        release_job(2);
        total++;
        if (ro[2] !== 1'b1 || vo[2] !== 1'b0) begin bad++; $display("FAIL zero_release got ready=%b valid=%b exp ready=1 valid=0", ro[2], vo[2]); end
    endtask

    task automatic test_table;
        ascon_state_t st, res, back;
        logic [4:0] c, got;
        int lat;
        st = '0;
        for (int j = 0; j < 64; j++) begin
            c = 5'(j % 32);
            st[0][j] = c[4];
            st[1][j] = c[3];
            st[2][j] = c[2];
            st[3][j] = c[1];
            st[4][j] = c[0];
        end
        run_job(2, st, lat, res);
        for (int j = 0; j < 64; j++) begin
            got = {res[0][j], res[1][j], res[2][j], res[3][j], res[4][j]};
            total++;
            if (got !== INV_T[j % 32]) begin bad++; $display("FAIL table_col j=%0d got=%h exp=%h", j, got, INV_T[j % 32]); end
        end
        back = apply_tab(res, 1'b1);
        total++;
        if (back !== st) begin bad++; $display("FAIL table_roundtrip got=%h exp=%h", back, st); end
        release_job(2);
    endtask

    task automatic test_latency;
        int ks [3] = '{0, 2, 3};
        int lats [3] = '{64, 8, 1};
        int lat;
        ascon_state_t st, res, exp_s;
        for (int i = 0; i < 3; i++) begin
            st = rand_state();
            exp_s = apply_tab(st, 1'b0);
            run_job(ks[i], st, lat, res);
            total++;
            if (lat != lats[i]) begin bad++; $display("FAIL latency inst=%0d got=%0d exp=%0d", ks[i], lat, lats[i]); end
            total++;
            if (res !== exp_s) begin bad++; $display("FAIL latency_result inst=%0d got=%h exp=%h", ks[i], res, exp_s); end
            release_job(ks[i]);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        ascon_state_t st, res;
        st = rand_state();
        run_job(2, st, lat, res);
        for (int c = 0; c < 20; c++) begin
            vi[2] = c[0];
            si[2] = rand_state();
            @(negedge clk);
            total++;
            if (so[2] !== res) begin bad++; $display("FAIL bp_hold c=%0d got=%h exp=%h", c, so[2], res); end
            total++;
            if (ro[2] !== 1'b0) begin bad++; $display("FAIL bp_ready c=%0d got=%b exp=0", c, ro[2]); end
            total++;
            if (vo[2] !== 1'b1) begin bad++; $display("FAIL bp_valid c=%0d got=%b exp=1", c, vo[2]); end
        end
        vi[2] = 1'b0;
        total++;
        if (res !== apply_tab(st, 1'b0)) begin bad++; $display("FAIL bp_result got=%h exp=%h", res, apply_tab(st, 1'b0)); end
        release_job(2);
        total++;
        if (ro[2] !== 1'b1 || vo[2] !== 1'b0) begin bad++; $display("FAIL bp_release got ready=%b valid=%b exp ready=1 valid=0", ro[2], vo[2]); end
    endtask

    task automatic test_reset_mid_busy;
        int lat;
        ascon_state_t st, res;
        @(negedge clk);
        vi[1] = 1'b1;
        si[1] = rand_state();
        @(negedge clk);
        vi[1] = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (vo[1] !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", vo[1]); end
        total++;
        if (ro[1] !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", ro[1]); end
        total++;
        if (so[1] !== '0) begin bad++; $display("FAIL midrst_state got=%h exp=0", so[1]); end
        rst = 1'b0;
        st = rand_state();
        run_job(1, st, lat, res);
        total++;
        if (lat != 16) begin bad++; $display("FAIL midrst_latency got=%0d exp=16", lat); end
        total++;
        if (res !== apply_tab(st, 1'b0)) begin bad++; $display("FAIL midrst_result got=%h exp=%h", res, apply_tab(st, 1'b0)); end
        release_job(1);
    endtask

    task automatic test_back_to_back;
        ascon_state_t sts [3];
        ascon_state_t exps [3];
        int cyc, na, no, last_acc, last_out;
        logic acc;
        for (int i = 0; i < 3; i++) begin
            sts[i] = rand_state();
            exps[i] = apply_tab(sts[i], 1'b0);
        end
        @(negedge clk);
        vi[2] = 1'b1;
        si[2] = sts[0];
        ri[2] = 1'b1;
        cyc = 0;
        na = 0;
        no = 0;
        last_acc = 0;
        last_out = 0;
        while (no < 3 && cyc < 100) begin
            acc = ro[2] && vi[2];
            total++;
            if (ro[2] === 1'b1 && vo[2] === 1'b1) begin bad++; $display("FAIL b2b_overlap cyc=%0d got ready=1 valid=1 exp not both", cyc); end
            if (vo[2] === 1'b1) begin
                total++;
                if (so[2] !== exps[no]) begin bad++; $display("FAIL b2b_result n=%0d got=%h exp=%h", no, so[2], exps[no]); end
                if (no > 0) begin
                    total++;
                    if (cyc - last_out != 10) begin bad++; $display("FAIL b2b_out_spacing n=%0d got=%0d exp=10", no, cyc - last_out); end
                end
                last_out = cyc;
                no++;
            end
            if (acc) begin
                if (na > 0) begin
                    total++;
                    if (cyc - last_acc != 10) begin bad++; $display("FAIL b2b_acc_spacing n=%0d got=%0d exp=10", na, cyc - last_acc); end
                end
                last_acc = cyc;
                na++;
            end
            @(negedge clk);
            cyc++;
            if (acc) begin
                if (na < 3) si[2] = sts[na];
                else vi[2] = 1'b0;
            end
        end
        vi[2] = 1'b0;
        ri[2] = 1'b0;
        total++;
        if (no != 3) begin bad++; $display("FAIL b2b_outputs got=%0d exp=3", no); end
        total++;
        if (na != 3) begin bad++; $display("FAIL b2b_accepts got=%0d exp=3", na); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_zero();
        test_table();
        test_latency();
        test_backpressure();
        test_reset_mid_busy();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ascon_inv_sbox_serial.md
# ascon_inv_sbox_serial

Serialized inverse of the Ascon 5-bit S-box layer (NIST SP 800-232). It accepts one 320-bit Ascon state over a valid/ready handshake and applies the inverse S-box to all 64 bit-sliced columns, LANES columns per cycle. It then returns the result on a second valid/ready handshake. It sits beside the permutation datapath and serves permutation-inversion checks and state-recovery debug paths; it trades latency for area against a fully parallel inverse layer.

## Interface
- LANES, default 8, columns processed per cycle; legal values 1, 2, 4, 8, 16, 32, 64. Any other value causes an elaboration error via `$error` in a generate-if.
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset; one clock, synchronous, active-high.
- valid_i  input  1  input state valid.
- ready_o  output  1  block can accept a state.
- state_array_i  input  ascon_pkg::ascon_state_t (5 x WORD_WIDTH=64)  state to invert.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts result.
- state_array_o  output  ascon_pkg::ascon_state_t  inverted state.

## Operation
- Column j of a state is the 5-bit value {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]}. s[0] is the MSB.
- For every column, the output column is INV[input column]. INV, listed for inputs 0..31 in hex: 14,1a,07,0d,00,09,0e,12,0a,06,1d,01,19,15,13,1e,18,16,0b,11,03,05,1c,1f,17,1b,04,08,0f,0c,10,02.
- INV is implemented as a case-based function. Array parameters are not used for the table.
- The datapath is a single 320-bit working register, col_q, plus a column counter, cnt_q, of width $clog2(64/LANES) (minimum 1 bit).
- FSM states: IDLE, BUSY, DONE.
  - IDLE: ready_o=1. When valid_i is high, the FSM loads state_array_i into the working register, clears the counter, and moves to BUSY.
  - BUSY: each cycle replaces columns [cnt*LANES, cnt*LANES+LANES-1] of the working register with their INV values and increments cnt. After the last group, cnt returns to 0 and the FSM moves to DONE.
  - DONE: valid_o=1 and state_array_o equals the working register. When ready_i is high, the FSM moves to IDLE.
- state_array_o is driven from the working register at all times, but it is meaningful only while valid_o is high.
- Transformed columns are never re-transformed: each column is written exactly once per job.
- Only IDLE accepts input. In IDLE, valid_i does not depend on ready_o.

## Timing
- Reset values: FSM=IDLE, ready_o=1, valid_o=0, cnt=0, state_array_o=0 (working register cleared).
- Latency: the accept edge is cycle 0. valid_o rises after the edge of cycle 64/LANES. For LANES=8 this is 8 cycles; for LANES=64 it is 1 cycle.
- While valid_o is high, the output is held stable until ready_i is sampled high. Backpressure of any length is legal.
- After the handshake edge in DONE, valid_o=0 and ready_o=1 on the next cycle. A new accept happens at the earliest on that cycle, so throughput is one state per 64/LANES+2 cycles. There is no same-cycle DONE-to-accept bypass.
- valid_i is ignored in BUSY and DONE, and ready_o=0 in those states.
- Reset asserted in any state, including mid-BUSY with a partially transformed register, returns all state to the reset values on the next edge. No partial result is ever presented.
- Reset takes priority over valid_i, ready_i and the counter update on the same edge.

## Test plan
- All-zero input, LANES=8: accept, then wait 8 cycles. Required: valid_o=1; s[0] and s[2] equal 64'hFFFF_FFFF_FFFF_FFFF; s[1], s[3] and s[4] equal 0.
- Exhaustive table: set column j to value j mod 32 (covers all 32 inputs twice). Required: each output column equals INV[j mod 32]. Then feed the output through the forward substitution_layer and require the original state back.
- Latency sweep: LANES in {1, 8, 64} with random states. Required: valid_o rises exactly 64, 8 and 1 cycles after accept. The result matches a reference model.
- Backpressure: hold ready_i=0 for 20 cycles in DONE while toggling valid_i and state_array_i. Required: state_array_o is unchanged, ready_o=0, and no new job starts. After ready_i=1, ready_o=1 on the next cycle.
- Reset mid-BUSY, LANES=4: accept a random state and assert rst_i at cycle 5. Required: on the next cycle valid_o=0, ready_o=1 and state_array_o=0. A subsequent job completes in exactly 16 cycles with the correct result.
- Back-to-back jobs: hold valid_i=1 continuously with three distinct states. Required: each is accepted only in IDLE, and the results emerge in order, each correct, spaced 64/LANES+2 cycles apart.
